// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise gate unit. It uses a valid/ready handshake, has a single
// output stage, can substitute an accumulator for B, registers result flags and keeps a
// saturating count of illegal ops.
module logic_unit_pipe #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   ACC_INIT  = '0,
  parameter int                 ERR_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic [2:0]            gateType,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      O,
  output logic                  zero,
  output logic                  ones,
  output logic                  parity,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NOT  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_ILL  = 3'b111
  } gate_e;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_o;
  logic                 r_zero;
  logic                 r_ones;
  logic                 r_parity;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0]     r_acc;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [WIDTH-1:0]     w_acc_eff;
  logic [WIDTH-1:0]     w_bop;
  logic [WIDTH-1:0]     w_result;
  logic                 w_illegal;
  gate_e                w_op;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // A same-cycle clear takes effect before the operation, so the beat sees ACC_INIT.
  assign w_acc_eff = acc_clr ? ACC_INIT : r_acc;
  assign w_bop     = acc_en ? w_acc_eff : B;
  assign w_op      = gate_e'(gateType);

  // NOTE: defaults are assigned before the case, so no path leaves an output unassigned and no latch is inferred.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (w_op)
      OP_AND:  w_result = A & w_bop;
      OP_OR:   w_result = A | w_bop;
      OP_NOT:  w_result = ~A;
      OP_NAND: w_result = ~(A & w_bop);
      OP_NOR:  w_result = ~(A | w_bop);
      OP_XOR:  w_result = A ^ w_bop;
      OP_XNOR: w_result = ~(A ^ w_bop);
      default: w_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_parity    <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_o         <= w_result;
      r_zero      <= (w_result == '0);
      r_ones      <= &w_result;
      r_parity    <= ^w_result;
      r_err       <= w_illegal;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // An illegal op never writes ACC. Only a legal op can outrank a pending clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_INIT;
    end else if (w_in_fire && acc_en && !w_illegal) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_in_fire && w_illegal && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign O         = r_o;
  assign zero      = r_zero;
  assign ones      = r_ones;
  assign parity    = r_parity;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit combinational gate selector.
- Applies one of seven bitwise gate operations to WIDTH-bit operands A and B, selected per beat by a 3-bit gateType.
- Adds a valid/ready handshake, one output register stage, an accumulate mode that substitutes an internal accumulator for B, result flags, and a saturating illegal-op counter.
- Sits between an operand producer and any consumer that may apply backpressure.

Parameters:
- WIDTH, 8: operand/result width in bits (≥1).
- ACC_INIT, {WIDTH{1'b0}}: accumulator value after reset and after acc_clr.
- ERR_CNT_W, 4: width of the saturating illegal-op counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B (ignored for NOT, and when acc_en=1).
- gateType  in  3  000 AND, 001 OR, 010 NOT(A), 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 illegal.
- acc_en  in  1  use ACC in place of B; write the result back to ACC.
- acc_clr  in  1  load ACC with ACC_INIT (sampled every cycle, independent of handshake).
- out_valid  out  1  result register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- O  out  WIDTH  registered result.
- zero  out  1  O == 0, registered with O.
- ones  out  1  O all ones, registered with O.
- parity  out  1  XOR-reduce of O, registered with O.
- err  out  1  beat carried an illegal gateType.
- err_cnt  out  ERR_CNT_W  saturating count of accepted illegal beats.

Behaviour:
- Reset (rst_n low, async): out_valid=0, O=0, zero=0, ones=0, parity=0, err=0, err_cnt=0, ACC=ACC_INIT. in_ready=1 on the first cycle after release.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
  - Input transfer: in_valid && in_ready at the rising edge.
  - Output transfer: out_valid && out_ready at the rising edge.
- Latency: 1 cycle, transfer edge to out_valid. One beat per clock is sustained while out_ready=1.
- Register update on input transfer:
  - O, flags and err load; out_valid goes to 1.
  - O, flags and err otherwise hold while out_valid && !out_ready. Output data must remain stable under backpressure.
- Register update without input transfer: out_valid clears on an output transfer, otherwise holds.
- in_valid may drop without a transfer; there are no protocol assertions on the input side.
- Operand select: Bop = acc_en ? ACCeff : B.
  - ACCeff = ACC_INIT if acc_clr is high in the same cycle, else ACC.
  - In effect, clear happens before operate.
- Result: R = op(A, Bop), all operations bitwise over WIDTH bits. NOT gives ~A.
- Illegal op (111): R=0, err=1, flags computed on R (zero=1, ones=0, parity=0).
- ACC update, priority order:
  1. Transfer with acc_en=1 and a legal op: ACC <= R.
  2. acc_clr=1: ACC <= ACC_INIT.
  3. Otherwise ACC holds.
  - An illegal op never writes ACC. If acc_clr is also high, ACC still clears.
- err_cnt: increments by 1 on each input transfer with gateType=111 and saturates at all ones. It is only cleared by reset.
- Mid-operation reset: all state returns to reset values immediately. A beat held under backpressure is discarded.

Test Plan (WIDTH=8, ACC_INIT=0):
- Op sweep: out_ready=1, one beat per op 000..110 with A=0xCA, B=0x5C → O = 0x48, 0xDE, 0x35, 0xB7, 0x21, 0x96, 0x69, each one cycle after its transfer. XOR beat has parity=0; XNOR beat has parity=0.
- Backpressure: beat AND 0xFF/0x0F, then out_ready=0 for 3 cycles while presenting OR 0x00/0x00 → O=0x0F stable with out_valid=1 and in_ready=0. Second beat held off; on out_ready=1 the next O=0x00 with zero=1.
- Accumulate: acc_en=1, XOR with A=0x01, 0x02, 0x04 back-to-back → O = 0x01, 0x03, 0x07. Then acc_clr=1 with a transfer, XOR A=0x10 → O=0x10.
- Illegal op: gateType=111 with acc_en=1, A=0xFF → O=0x00, err=1, zero=1, ACC unchanged (next XOR A=0 returns the prior ACC). 20 illegal beats → err_cnt saturates at 0xF.
- Ones flag: NAND A=0x00, B=0x00 → O=0xFF, ones=1, parity=0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid, O, flags, err_cnt at 0 asynchronously and ACC=0. After release, in_ready=1 and the next beat has normal 1-cycle latency.
